// File: rtl/pf_ddr3_lane_dly_pkg.sv
// Shared types and defaults for the DDR3 lane delay-line controller.
package pf_ddr3_lane_dly_pkg;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_MOVE   = 2'b01,
      OP_CLKSEL = 2'b10,
      OP_RSVD   = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETUP      = 3'd1,
      PULSE      = 3'd2,
      GAP        = 3'd3,
      PAUSE_PRE  = 3'd4,
      CLK_UPD    = 3'd5,
      PAUSE_POST = 3'd6,
      FIN        = 3'd7
   } state_t;

   localparam int unsigned MOVE_GAP_DEF     = 4;
   localparam int unsigned PAUSE_CYCLES_DEF = 8;
   localparam logic [7:0]  LOAD_TAP_DEF     = 8'd1;

   // True when one more step in the given direction would leave the tap range.
   function automatic logic tap_at_limit(input logic [7:0] tap, input logic dir);
      return dir ? (tap == 8'hFF) : (tap == 8'h00);
   endfunction

endpackage

// File: rtl/pf_ddr3_lane_dly_ctrl_if.sv
// Command handshake bundle between a requester and the delay-line controller.
interface pf_ddr3_lane_dly_ctrl_if;

   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_OP;
   logic       CMD_SEL;
   logic       CMD_DIR;
   logic [7:0] CMD_COUNT;
   logic [2:0] CMD_CLK_SEL;

   modport master (
      output CMD_VALID, CMD_OP, CMD_SEL, CMD_DIR, CMD_COUNT, CMD_CLK_SEL,
      input  CMD_READY
   );

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_SEL, CMD_DIR, CMD_COUNT, CMD_CLK_SEL,
      output CMD_READY
   );

endinterface

// File: rtl/pf_ddr3_lane_dly_timer.sv
// 4-bit loadable down-counter; shared interval timer for gap and pause phases.
module pf_ddr3_lane_dly_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       en,
   output logic       zero
);

   logic [3:0] count;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - 4'd1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pf_ddr3_lane_dly_ctrl.sv
// Sequencer for lane delay-line LOAD/MOVE pulses and paused read-clock reselection.
module pf_ddr3_lane_dly_ctrl
   import pf_ddr3_lane_dly_pkg::*;
#(
   parameter int unsigned MOVE_GAP     = MOVE_GAP_DEF,
   parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF,
   parameter logic [7:0]  LOAD_TAP     = LOAD_TAP_DEF
) (
   input  logic       FAB_CLK,
   input  logic       RESET,
   pf_ddr3_lane_dly_ctrl_if.slave cmd,
   output logic       DONE,
   output logic       ERR,
   output logic [7:0] RX_TAP,
   output logic [7:0] TX_TAP,
   output logic       DELAY_LINE_SEL,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_DIRECTION,
   output logic       DELAY_LINE_MOVE,
   output logic [2:0] READ_CLK_SEL,
   output logic       HS_IO_CLK_PAUSE,
   input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
   input  logic       TX_DELAY_LINE_OUT_OF_RANGE
);

   // Timer reloads are "cycles - 1" style: the phase ends on the zero cycle.
   localparam logic [3:0] GAP_LOAD   = 4'(MOVE_GAP - 2);
   localparam logic [3:0] PAUSE_LOAD = 4'(PAUSE_CYCLES - 1);

   state_t     state;
   state_t     state_nx;
   op_t        op_q;
   logic       sel_q;
   logic       dir_q;
   logic [7:0] count_q;
   logic [2:0] clk_sel_q;
   logic       err_q;
   logic [7:0] rx_tap;
   logic [7:0] tx_tap;
   logic [2:0] rcs_q;

   logic       accept;
   logic       abort;
   logic       t_load;
   logic [3:0] t_val;
   logic       t_en;
   logic       t_zero;
   logic [7:0] cur_tap;
   logic [7:0] next_tap;
   logic       cur_oor;
   logic       at_limit;
   logic       line_active;

   assign accept   = (state == IDLE) && cmd.CMD_VALID;
   assign cur_tap  = sel_q ? tx_tap : rx_tap;
   assign cur_oor  = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
   assign at_limit = tap_at_limit(cur_tap, dir_q);
   assign t_en     = (state == GAP) || (state == PAUSE_PRE) || (state == PAUSE_POST);

   pf_ddr3_lane_dly_timer u_timer (
      .clk      (FAB_CLK),
      .rst      (RESET),
      .load     (t_load),
      .load_val (t_val),
      .en       (t_en),
      .zero     (t_zero)
   );

   // Next-state decode; limit/range aborts are decided before a pulse is entered.
   always_comb begin
      state_nx = state;
      t_load   = 1'b0;
      t_val    = '0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (cmd.CMD_VALID) begin
               case (cmd.CMD_OP)
                  OP_LOAD, OP_MOVE: state_nx = SETUP;
                  OP_CLKSEL: begin
                     state_nx = PAUSE_PRE;
                     t_load   = 1'b1;
                     t_val    = PAUSE_LOAD;
                  end
                  default: state_nx = FIN;
               endcase
            end
         end
         SETUP: begin
            if (op_q == OP_LOAD)
               state_nx = PULSE;
            else if (count_q == '0)
               state_nx = FIN;
            else if (at_limit) begin
               state_nx = FIN;
               abort    = 1'b1;
            end else
               state_nx = PULSE;
         end
         PULSE: begin
            state_nx = GAP;
            t_load   = 1'b1;
            t_val    = GAP_LOAD;
         end
         GAP: begin
            if (t_zero) begin
               if (cur_oor) begin
                  state_nx = FIN;
                  abort    = 1'b1;
               end else if ((op_q == OP_LOAD) || (count_q == '0))
                  state_nx = FIN;
               else if (at_limit) begin
                  state_nx = FIN;
                  abort    = 1'b1;
               end else
                  state_nx = PULSE;
            end
         end
         PAUSE_PRE:  if (t_zero) state_nx = CLK_UPD;
         CLK_UPD: begin
            state_nx = PAUSE_POST;
            t_load   = 1'b1;
            t_val    = PAUSE_LOAD;
         end
         PAUSE_POST: if (t_zero) state_nx = FIN;
         FIN:        state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // State, captured command fields, remaining-pulse count and sticky error.
   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state     <= IDLE;
         op_q      <= OP_LOAD;
         sel_q     <= 1'b0;
         dir_q     <= 1'b0;
         count_q   <= '0;
         clk_sel_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q      <= op_t'(cmd.CMD_OP);
            sel_q     <= cmd.CMD_SEL;
            dir_q     <= cmd.CMD_DIR;
            count_q   <= cmd.CMD_COUNT;
            clk_sel_q <= cmd.CMD_CLK_SEL;
            err_q     <= (cmd.CMD_OP == OP_RSVD);
         end else begin
            if (abort)
               err_q <= 1'b1;
            if ((state == PULSE) && (op_q == OP_MOVE))
               count_q <= count_q - 8'd1;
         end
      end
   end

   // Tap value the selected line takes after the current pulse (saturating).
   always_comb begin
      next_tap = cur_tap;
      if (op_q == OP_LOAD)
         next_tap = LOAD_TAP;
      else if (dir_q)
         next_tap = (cur_tap == 8'hFF) ? cur_tap : cur_tap + 8'd1;
      else
         next_tap = (cur_tap == 8'h00) ? cur_tap : cur_tap - 8'd1;
   end

   // Tap trackers follow each LOAD/MOVE pulse on the selected line.
   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         rx_tap <= LOAD_TAP;
         tx_tap <= LOAD_TAP;
      end else if (state == PULSE) begin
         if (sel_q)
            tx_tap <= next_tap;
         else
            rx_tap <= next_tap;
      end
   end

   // Read clock select changes only on the edge leaving CLK_UPD, inside the pause.
   always_ff @(posedge FAB_CLK) begin
      if (RESET)
         rcs_q <= '0;
      else if (state == CLK_UPD)
         rcs_q <= clk_sel_q;
   end

   assign line_active = ((op_q == OP_LOAD) || (op_q == OP_MOVE)) &&
                        (state inside {SETUP, PULSE, GAP, FIN});

   assign cmd.CMD_READY        = (state == IDLE);
   assign DONE                 = (state == FIN);
   assign ERR                  = err_q;
   assign RX_TAP               = rx_tap;
   assign TX_TAP               = tx_tap;
   assign DELAY_LINE_SEL       = line_active && sel_q;
   assign DELAY_LINE_DIRECTION = line_active && dir_q;
   assign DELAY_LINE_LOAD      = (state == PULSE) && (op_q == OP_LOAD);
   assign DELAY_LINE_MOVE      = (state == PULSE) && (op_q == OP_MOVE);
   assign READ_CLK_SEL         = rcs_q;
   assign HS_IO_CLK_PAUSE      = state inside {PAUSE_PRE, CLK_UPD, PAUSE_POST};

endmodule

// File: tb/tb_pf_ddr3_lane_dly_ctrl.sv
// Scoreboard bench for pf_ddr3_lane_dly_ctrl with default timing parameters.
module tb_pf_ddr3_lane_dly_ctrl;

   localparam int unsigned G  = 4;
   localparam int unsigned P  = 8;
   localparam logic [7:0]  LT = 8'd1;

   logic       clk = 1'b0;
   logic       rst;
   logic       done;
   logic       err;
   logic [7:0] rx_tap;
   logic [7:0] tx_tap;
   logic       dl_sel;
   logic       dl_load;
   logic       dl_dir;
   logic       dl_move;
   logic [2:0] read_clk_sel;
   logic       hs_pause;
   logic       rx_oor;
   logic       tx_oor;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      name;
      logic       err;
      logic [7:0] rx;
      logic [7:0] tx;
      logic [2:0] rcs;
      int         lat;
      int         loads;
      int         moves;
   } exp_t;

   exp_t sb[$];
   logic [7:0] m_rx = LT;
   logic [7:0] m_tx = LT;
   logic [2:0] m_rcs = 3'b000;

   pf_ddr3_lane_dly_ctrl_if cmd_if ();

   pf_ddr3_lane_dly_ctrl #(
      .MOVE_GAP     (G),
      .PAUSE_CYCLES (P),
      .LOAD_TAP     (LT)
   ) dut (
      .FAB_CLK                    (clk),
      .RESET                      (rst),
      .cmd                        (cmd_if),
      .DONE                       (done),
      .ERR                        (err),
      .RX_TAP                     (rx_tap),
      .TX_TAP                     (tx_tap),
      .DELAY_LINE_SEL             (dl_sel),
      .DELAY_LINE_LOAD            (dl_load),
      .DELAY_LINE_DIRECTION       (dl_dir),
      .DELAY_LINE_MOVE            (dl_move),
      .READ_CLK_SEL               (read_clk_sel),
      .HS_IO_CLK_PAUSE            (hs_pause),
      .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
      .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_ready"}, cmd_if.CMD_READY, 1);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_err"}, err, 0);
      check({pfx, "_rx_tap"}, rx_tap, LT);
      check({pfx, "_tx_tap"}, tx_tap, LT);
      check({pfx, "_dl_outs"}, {dl_sel, dl_load, dl_dir, dl_move}, 0);
      check({pfx, "_rcs"}, read_clk_sel, 0);
      check({pfx, "_pause"}, hs_pause, 0);
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic sel, input logic dir,
                            input logic [7:0] count, input logic [2:0] csel);
      @(negedge clk);
      cmd_if.CMD_VALID   = 1'b1;
      cmd_if.CMD_OP      = op;
      cmd_if.CMD_SEL     = sel;
      cmd_if.CMD_DIR     = dir;
      cmd_if.CMD_COUNT   = count;
      cmd_if.CMD_CLK_SEL = csel;
      @(posedge clk);
      @(negedge clk);
      cmd_if.CMD_VALID   = 1'b0;
      cmd_if.CMD_OP      = 2'($urandom);
      cmd_if.CMD_SEL     = 1'($urandom);
      cmd_if.CMD_DIR     = 1'($urandom);
      cmd_if.CMD_COUNT   = 8'($urandom);
      cmd_if.CMD_CLK_SEL = 3'($urandom);
   endtask

   task automatic run_cmd(input string name, input logic [1:0] op, input logic sel,
                          input logic dir, input logic [7:0] count, input logic [2:0] csel);
      exp_t e;
      logic oor;
      int   t;
      int   steps;
      bit   seen = 0;
      int   lat = -1, moves = 0, loads = 0, load_k = -1, first_move = -1, last_move = 0;
      int   gap_bad = 0, hold_bad = 0, busy_ready = 0, both = 0;
      int   pause_n = 0, pause_first = -1, rcs_k = -1;
      logic [2:0] rcs_prev;

      // reference model of the command outcome
      oor     = sel ? tx_oor : rx_oor;
      e.name  = name;
      e.err   = 1'b0;
      e.rx    = m_rx;
      e.tx    = m_tx;
      e.rcs   = m_rcs;
      e.loads = 0;
      e.moves = 0;
      e.lat   = 0;
      case (op)
         2'b00: begin
            if (sel) e.tx = LT; else e.rx = LT;
            e.loads = 1;
            e.err   = oor;
            e.lat   = G + 1;
         end
         2'b01: begin
            t     = sel ? int'(m_tx) : int'(m_rx);
            steps = 0;
            while (steps < int'(count)) begin
               if (dir ? (t == 255) : (t == 0)) begin
                  e.err = 1'b1;
                  break;
               end
               t = dir ? t + 1 : t - 1;
               steps++;
               if (oor) begin
                  e.err = 1'b1;
                  break;
               end
            end
            e.moves = steps;
            e.lat   = 1 + steps * int'(G);
            if (sel) e.tx = 8'(t); else e.rx = 8'(t);
         end
         2'b10: begin
            e.rcs = csel;
            e.lat = 2 * P + 1;
         end
         default: begin
            e.err = 1'b1;
            e.lat = 0;
         end
      endcase
      sb.push_back(e);
      m_rx  = e.rx;
      m_tx  = e.tx;
      m_rcs = e.rcs;

      @(negedge clk);
      check({name, "_ready_idle"}, cmd_if.CMD_READY, 1);
      rcs_prev = read_clk_sel;
      drive_cmd(op, sel, dir, count, csel);

      for (int k = 0; k < 2000 && !seen; k++) begin
         if (k > 0) @(negedge clk);
         if (dl_load && dl_move) both++;
         if (dl_move) begin
            if (moves == 0) first_move = k;
            else if (k - last_move != int'(G)) gap_bad++;
            last_move = k;
            moves++;
         end
         if (dl_load) begin
            if (loads == 0) load_k = k;
            loads++;
         end
         if (hs_pause) begin
            if (pause_n == 0) pause_first = k;
            pause_n++;
         end
         if (read_clk_sel !== rcs_prev) begin
            rcs_k    = k;
            rcs_prev = read_clk_sel;
         end
         if (op < 2) begin
            if ((dl_sel !== sel) || (dl_dir !== dir)) hold_bad++;
         end else if (dl_sel | dl_dir | dl_load | dl_move) hold_bad++;
         if (cmd_if.CMD_READY) busy_ready++;
         if (done) begin
            seen = 1;
            lat  = k;
         end
      end

      e = sb.pop_front();
      check({e.name, "_done_seen"}, seen, 1);
      if (seen) begin
         check({e.name, "_latency"}, lat, e.lat);
         check({e.name, "_err"}, err, e.err);
         check({e.name, "_rx_tap"}, rx_tap, e.rx);
         check({e.name, "_tx_tap"}, tx_tap, e.tx);
         check({e.name, "_rcs"}, read_clk_sel, e.rcs);
         check({e.name, "_loads"}, loads, e.loads);
         check({e.name, "_moves"}, moves, e.moves);
         check({e.name, "_gap_spacing"}, gap_bad, 0);
         check({e.name, "_sel_dir_hold"}, hold_bad, 0);
         check({e.name, "_ready_busy"}, busy_ready, 0);
         check({e.name, "_load_move_excl"}, both, 0);
         if (e.loads > 0) check({e.name, "_load_after_setup"}, load_k, 1);
         if (e.moves > 0) check({e.name, "_move_after_setup"}, first_move, 1);
         if (op == 2'b10) begin
            check({e.name, "_pause_len"}, pause_n, 2 * P + 1);
            check({e.name, "_pause_first"}, pause_first, 0);
            check({e.name, "_rcs_delay"}, rcs_k - pause_first, P + 1);
         end else
            check({e.name, "_no_pause"}, pause_n, 0);
         @(negedge clk);
         check({e.name, "_done_one_cycle"}, done, 0);
         check({e.name, "_err_sticky"}, err, e.err);
         check({e.name, "_ready_after"}, cmd_if.CMD_READY, 1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   seen_done;
      rst                = 1'b1;
      rx_oor             = 1'b0;
      tx_oor             = 1'b0;
      cmd_if.CMD_VALID   = 1'b0;
      cmd_if.CMD_OP      = 2'b00;
      cmd_if.CMD_SEL     = 1'b0;
      cmd_if.CMD_DIR     = 1'b0;
      cmd_if.CMD_COUNT   = 8'd0;
      cmd_if.CMD_CLK_SEL = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("por");

      run_cmd("load_rx",       2'b00, 1'b0, 1'b0, 8'd0,   3'b000);
      run_cmd("move_tx_up3",   2'b01, 1'b1, 1'b1, 8'd3,   3'b000);
      run_cmd("move_rx_dn5",   2'b01, 1'b0, 1'b0, 8'd5,   3'b000);
      run_cmd("move_rx_cnt0",  2'b01, 1'b0, 1'b0, 8'd0,   3'b000);
      run_cmd("move_rx_at0",   2'b01, 1'b0, 1'b0, 8'd1,   3'b000);
      run_cmd("clksel_101",    2'b10, 1'b0, 1'b0, 8'd0,   3'b101);
      tx_oor = 1'b1;
      run_cmd("move_tx_oor",   2'b01, 1'b1, 1'b1, 8'd10,  3'b000);
      tx_oor = 1'b0;
      rx_oor = 1'b1;
      run_cmd("move_tx_rxoor", 2'b01, 1'b1, 1'b1, 8'd2,   3'b000);
      rx_oor = 1'b0;
      run_cmd("reserved_op",   2'b11, 1'b0, 1'b0, 8'd0,   3'b000);
      run_cmd("move_tx_sat",   2'b01, 1'b1, 1'b1, 8'd255, 3'b000);
      run_cmd("load_tx",       2'b00, 1'b1, 1'b0, 8'd0,   3'b000);
      run_cmd("clksel_010",    2'b10, 1'b1, 1'b1, 8'd0,   3'b010);

      // reset while a MOVE is in flight
      drive_cmd(2'b01, 1'b1, 1'b1, 8'd10, 3'b000);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      m_rx  = LT;
      m_tx  = LT;
      m_rcs = 3'b000;
      check_reset_state("mid_rst");
      seen_done = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      check("mid_rst_no_done", seen_done, 0);

      run_cmd("post_rst_move", 2'b01, 1'b0, 1'b1, 8'd2,   3'b000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pf_ddr3_lane_dly_ctrl.md
PF_DDR3_LANE_DLY_CTRL -- requirements
Module: pf_ddr3_lane_dly_ctrl

Interface
REQ-001 SHALL have parameter MOVE_GAP, default 4: cycles from one DELAY_LINE_MOVE pulse start to the next (legal range 2..15).
REQ-002 SHALL have parameter PAUSE_CYCLES, default 8: HS_IO_CLK_PAUSE hold cycles before and after a READ_CLK_SEL update (legal range 1..15).
REQ-003 SHALL have parameter LOAD_TAP, default 8'd1: tap value restored by LOAD.
REQ-004 SHALL have ports, clock and reset first:
- FAB_CLK  in  1: single clock for all logic.
- RESET  in  1: synchronous, active-high reset.
- CMD_VALID  in  1 / CMD_READY  out  1: command handshake; accepted when both are high on a FAB_CLK edge.
- CMD_OP  in  2: 00 LOAD, 01 MOVE, 10 CLKSEL, 11 reserved.
- CMD_SEL  in  1: target line, 0 RX, 1 TX.
- CMD_DIR  in  1: 1 increment, 0 decrement.
- CMD_COUNT  in  8: taps to move.
- CMD_CLK_SEL  in  3: new READ_CLK_SEL value.
- DONE  out  1: one-cycle completion pulse.
- ERR  out  1: sticky error of the last command.
- RX_TAP / TX_TAP  out  8 each: tracked tap positions.
- DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE  out  1 each: lane controller delay-line controls.
- READ_CLK_SEL  out  3: lane controller read clock select.
- HS_IO_CLK_PAUSE  out  1: raw pause request to the lane pause synchroniser.
- RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE  in  1 each: lane controller range flags.

Function
REQ-005 SHALL use FSM states IDLE, SETUP, PULSE, GAP, PAUSE_PRE, CLK_UPD, PAUSE_POST, FIN.
REQ-006 SHALL assert CMD_READY only in IDLE; a command is captured on the accepting edge and CMD_* are don't-care afterwards.
REQ-007 SHALL handle a capture as follows: LOAD/MOVE -> SETUP; CLKSEL -> PAUSE_PRE; reserved op -> FIN with ERR=1.
REQ-008 SHALL, in SETUP, drive DELAY_LINE_SEL=CMD_SEL and DELAY_LINE_DIRECTION=CMD_DIR for exactly one cycle before any LOAD/MOVE pulse.
REQ-009 SHALL hold SEL/DIRECTION stable from SETUP through FIN.
REQ-010 SHALL execute LOAD as: PULSE drives DELAY_LINE_LOAD high one cycle; the selected tap becomes LOAD_TAP; GAP for MOVE_GAP-1 cycles; then FIN.
REQ-011 SHALL execute MOVE with CMD_COUNT=0 as SETUP -> FIN with no pulses.
REQ-012 SHALL execute MOVE with CMD_COUNT>0 as: each PULSE cycle drives DELAY_LINE_MOVE high for one cycle and steps the selected tap by ±1; GAP holds MOVE low for MOVE_GAP-1 cycles; exactly CMD_COUNT pulses are issued.
REQ-013 SHALL abort a MOVE to FIN with ERR=1, without issuing the pulse, when the selected tap is 255 with DIR=1 or 0 with DIR=0; tap counters SHALL saturate and never wrap.
REQ-014 SHALL abort to FIN with ERR=1 if the selected OUT_OF_RANGE input is high in the last GAP cycle.
REQ-015 SHALL execute CLKSEL as: HS_IO_CLK_PAUSE high from PAUSE_PRE entry; READ_CLK_SEL updated after PAUSE_CYCLES cycles (CLK_UPD, 1 cycle); pause held PAUSE_CYCLES more cycles in PAUSE_POST; then deasserted in FIN.
REQ-016 SHALL pulse DONE for one cycle in FIN, then return to IDLE.
REQ-017 SHALL hold ERR until the next command is accepted, when it clears.
REQ-018 SHALL keep every delay-line output low outside the states named above; at most one of LOAD/MOVE SHALL be high in any cycle.

Reset
REQ-019 SHALL, with RESET high on a FAB_CLK edge in any state: state=IDLE; CMD_READY=1 on the next cycle; DONE=0; ERR=0; RX_TAP=TX_TAP=LOAD_TAP; all delay-line outputs 0; READ_CLK_SEL=3'b000; HS_IO_CLK_PAUSE=0. A command in flight is dropped with no DONE.

Structure
REQ-020 SHALL place the op-code encoding, the FSM state enum and the parameter defaults in package pf_ddr3_lane_dly_pkg.
REQ-021 SHALL use one sub-module, pf_ddr3_lane_dly_timer: a 4-bit loadable down-counter with a zero flag, shared by GAP, PAUSE_PRE and PAUSE_POST.

Verification
REQ-022 SHALL cover: LOAD RX after reset -> SEL=0 for 1 cycle, one LOAD pulse, RX_TAP=1, DONE 5 cycles after accept, ERR=0.
REQ-023 SHALL cover: MOVE TX DIR=1 COUNT=3 -> 3 MOVE pulses spaced 4 cycles apart, TX_TAP=4, one DONE pulse.
REQ-024 SHALL cover: MOVE RX DIR=0 COUNT=5 from tap 1 -> one pulse, then abort; RX_TAP=0, ERR=1, DONE pulsed.
REQ-025 SHALL cover: CLKSEL 3'b101 -> PAUSE high 17 cycles; READ_CLK_SEL changes 9 cycles after PAUSE rises.
REQ-026 SHALL cover: OUT_OF_RANGE forced high during MOVE COUNT=10 -> abort after the first pulse with ERR=1.
REQ-027 SHALL cover: RESET mid-MOVE -> next cycle all outputs at reset values, no DONE, CMD_READY=1.
